seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, quotient and remainder width in bits, with WIDTH >= 4.
REQ-002 SHALL have port clock  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ctrl_DIV  input  1  start strobe, sampled on each rising clock edge.
REQ-005 SHALL have port data_operandA  input  WIDTH  dividend, two's complement, sampled only on a start edge.
REQ-006 SHALL have port data_operandB  input  WIDTH  divisor, two's complement, sampled only on a start edge.
REQ-007 SHALL have port data_result  output  WIDTH  quotient, registered.
REQ-008 SHALL have port data_remainder  output  WIDTH  remainder, registered.
REQ-009 SHALL have port data_exception  output  1  divide-by-zero or overflow flag, registered.
REQ-010 SHALL have port data_resultRDY  output  1  one-cycle completion pulse, registered.
REQ-011 SHALL have port busy  output  1  high while an operation is in progress.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 SHALL, on a rising edge with ctrl_DIV=1 in any state, latch both operands, clear the iteration counter, and enter BUSY (start edge S).
REQ-014 SHALL, when ctrl_DIV=1 arrives in BUSY, abort the current operation with no RDY pulse and restart with the new operands.
REQ-015 SHALL compute |A|/|B| by restoring shift-subtract, one quotient bit per cycle, MSB first, over exactly WIDTH cycles using a WIDTH+1-bit partial remainder.
REQ-016 SHALL use a counter that counts 0..WIDTH-1 in BUSY and SHALL go BUSY->DONE on the edge where the counter equals WIDTH-1.
REQ-017 SHALL update data_result, data_remainder and data_exception, and set data_resultRDY=1, on edge S+WIDTH+1 (the DONE entry edge plus one), with the FSM entering IDLE on that same edge.
REQ-018 SHALL deassert data_resultRDY on the following edge unless a new operation completes on that edge.
REQ-019 SHALL hold data_result, data_remainder and data_exception stable from the RDY edge until the next RDY edge.
REQ-020 SHALL round quotients toward zero: quotient sign = sign(A) XOR sign(B); remainder sign = sign(A); A = B*Q + R.
REQ-021 SHALL, for divide-by-zero (B=0), complete with the normal latency and give data_result=0, data_remainder=A, data_exception=1.
REQ-022 SHALL, for overflow (A = most-negative value and B = -1), complete with the normal latency and give data_result=0x8000_0000 (WIDTH=32), data_remainder=0, data_exception=1.
REQ-023 SHALL set data_exception=0 for all other operand pairs.
REQ-024 SHALL drive busy=1 in BUSY and DONE and busy=0 in IDLE.
REQ-025 SHALL ignore operand changes outside start edges.

Reset
REQ-026 SHALL, while reset_n=0, immediately force state=IDLE, counter=0, data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0 and busy=0, regardless of clock.
REQ-027 SHALL discard any in-flight operation when reset is asserted mid-operation, with no RDY pulse afterward.
REQ-028 SHALL ignore ctrl_DIV on any edge where reset_n=0, and SHALL accept a start on the first edge after reset_n rises.

Verification
REQ-029 SHALL be verified by basic divide: A=100, B=7, start -> RDY exactly 33 edges later (WIDTH=32), Q=14, R=2, exc=0.
REQ-030 SHALL be verified by signed divides: A=-100, B=7 -> Q=-14, R=-2; and A=100, B=-7 -> Q=-14, R=2; both with exc=0.
REQ-031 SHALL be verified by divide-by-zero: A=0x1234, B=0 -> Q=0, R=0x1234, exc=1, RDY at normal latency.
REQ-032 SHALL be verified by overflow: A=0x8000_0000, B=0xFFFF_FFFF -> Q=0x8000_0000, R=0, exc=1.
REQ-033 SHALL be verified by restart: start 100/7, then start 50/5 ten cycles later -> exactly one RDY, 33 edges after the second start, Q=10, R=0.
REQ-034 SHALL be verified by reset mid-op: pulse reset_n low for a partial cycle at iteration 15 -> all outputs 0 immediately, and no RDY for 40 cycles after release.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per clock, with sign fix-up and exception flagging at the end.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             div0_q, div0_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             exc_q, exc_d;
   logic             rdy_q, rdy_d;
   logic             busy_q, busy_d;

   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   rem_shift, trial;
   logic             q_bit;

   always_comb begin
      a_abs = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
      b_abs = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
      // The dividend register shifts its MSB into the remainder and takes the quotient bit in at the bottom.
      rem_shift = {rem_q, dvd_q[WIDTH-1]};
      trial     = rem_shift - {1'b0, dvs_q};
      q_bit     = ~trial[WIDTH];
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      a_d         = a_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      div0_d      = div0_q;
      ovf_d       = ovf_q;
      result_d    = result_q;
      remainder_d = remainder_q;
      exc_d       = exc_q;
      rdy_d       = 1'b0;

      if (ctrl_DIV) begin
         state_d = BUSY;
         cnt_d   = '0;
         rem_d   = '0;
         dvd_d   = a_abs;
         dvs_d   = b_abs;
         a_d     = data_operandA;
         q_neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         r_neg_d = data_operandA[WIDTH-1];
         div0_d  = (data_operandB == '0);
         ovf_d   = (data_operandA == MOST_NEG) && (data_operandB == '1);
      end else begin
         case (state_q)
            BUSY: begin
               rem_d = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
               dvd_d = {dvd_q[WIDTH-2:0], q_bit};
               if (cnt_q == CNT_LAST) begin
                  state_d = DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               state_d = IDLE;
               rdy_d   = 1'b1;
               if (div0_q) begin
                  result_d    = '0;
                  remainder_d = a_q;
                  exc_d       = 1'b1;
               end else if (ovf_q) begin
                  result_d    = MOST_NEG;
                  remainder_d = '0;
                  exc_d       = 1'b1;
               end else begin
                  result_d    = q_neg_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
                  remainder_d = r_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
                  exc_d       = 1'b0;
               end
            end
            default: ;
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         a_q         <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         div0_q      <= 1'b0;
         ovf_q       <= 1'b0;
         result_q    <= '0;
         remainder_q <= '0;
         exc_q       <= 1'b0;
         rdy_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         a_q         <= a_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         div0_q      <= div0_d;
         ovf_q       <= ovf_d;
         result_q    <= result_d;
         remainder_q <= remainder_d;
         exc_q       <= exc_d;
         rdy_q       <= rdy_d;
         busy_q      <= busy_d;
      end
   end

   assign data_result    = result_q;
   assign data_remainder = remainder_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider (WIDTH=32): latency, signed results,
// exceptions, restart and asynchronous reset behaviour.
module tb_seq_divider;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         ctrl_DIV = 1'b0;
   logic [W-1:0] data_operandA = '0;
   logic [W-1:0] data_operandB = '0;
   logic [W-1:0] data_result;
   logic [W-1:0] data_remainder;
   logic         data_exception;
   logic         data_resultRDY;
   logic         busy;

   int n_cmp  = 0;
   int n_fail = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_remainder (data_remainder),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   // Drive a start strobe for exactly one rising edge; returns #1 after that edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1;
      ctrl_DIV = 1'b0;
   endtask

   // Count edges until RDY is seen; returns limit+1 if it never appears.
   task automatic wait_rdy(input int limit, output int edges);
      edges = limit + 1;
      for (int i = 1; i <= limit; i++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY === 1'b1) begin
            edges = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      int edges;
      reset_n       = 1'b0;
      ctrl_DIV      = 1'b1;
      data_operandA = 32'd100;
      data_operandB = 32'd7;
      repeat (3) @(posedge clock);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_ctrl: busy=%b rdy=%b, required 0/0", busy, data_resultRDY);
      end
      n_cmp++;
      if (data_result !== '0 || data_remainder !== '0 || data_exception !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: Q=%h R=%h exc=%b, required 0/0/0",
                  data_result, data_remainder, data_exception);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      ctrl_DIV = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL first_edge_start: busy=%b, required 1", busy);
      end
      wait_rdy(40, edges);
      n_cmp++;
      if (edges !== 33) begin
         n_fail++;
         $display("[TB] FAIL post_reset_latency: %0d edges, required 33", edges);
      end
      n_cmp++;
      if (data_result !== 32'd14 || data_remainder !== 32'd2) begin
         n_fail++;
         $display("[TB] FAIL post_reset_result: Q=%0d R=%0d, required 14/2", data_result, data_remainder);
      end
   endtask

   task automatic test_basic;
      int edges;
      start_op(32'd100, 32'd7);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL basic_busy: busy=%b, required 1", busy);
      end
      data_operandA = 32'hDEAD_BEEF;
      data_operandB = 32'd3;
      wait_rdy(40, edges);
      n_cmp++;
      if (edges !== 33) begin
         n_fail++;
         $display("[TB] FAIL basic_latency: %0d edges, required 33", edges);
      end
      n_cmp++;
      if (data_result !== 32'd14 || data_remainder !== 32'd2 || data_exception !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL basic_result: Q=%0d R=%0d exc=%b, required 14/2/0",
                  data_result, data_remainder, data_exception);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL basic_idle: busy=%b, required 0", busy);
      end
      @(posedge clock);
      #1;
      n_cmp++;
      if (data_resultRDY !== 1'b0 || data_result !== 32'd14 || data_remainder !== 32'd2) begin
         n_fail++;
         $display("[TB] FAIL basic_hold: rdy=%b Q=%0d R=%0d, required 0/14/2",
                  data_resultRDY, data_result, data_remainder);
      end
   endtask

   task automatic test_signed;
      logic [W-1:0] va [5] = '{-32'sd100, 32'd100, -32'sd100, 32'h7FFF_FFFF, -32'sd7};
      logic [W-1:0] vb [5] = '{32'd7, -32'sd7, -32'sd7, 32'd3, 32'd100};
      logic [W-1:0] vq [5] = '{-32'sd14, -32'sd14, 32'd14, 32'd715827882, 32'd0};
      logic [W-1:0] vr [5] = '{-32'sd2, 32'd2, -32'sd2, 32'd1, -32'sd7};
      int edges;
      for (int i = 0; i < 5; i++) begin
         start_op(va[i], vb[i]);
         wait_rdy(40, edges);
         n_cmp++;
         if (edges !== 33 || data_result !== vq[i] || data_remainder !== vr[i] || data_exception !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL signed_%0d: edges=%0d Q=%h R=%h exc=%b, required 33/%h/%h/0",
                     i, edges, data_result, data_remainder, data_exception, vq[i], vr[i]);
         end
      end
   endtask

   task automatic test_div_zero;
      int edges;
      start_op(32'h1234, 32'h0);
      wait_rdy(40, edges);
      n_cmp++;
      if (edges !== 33 || data_result !== 32'h0 || data_remainder !== 32'h1234 || data_exception !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL div_zero: edges=%0d Q=%h R=%h exc=%b, required 33/0/1234/1",
                  edges, data_result, data_remainder, data_exception);
      end
   endtask

   task automatic test_overflow;
      int edges;
      start_op(32'h8000_0000, 32'hFFFF_FFFF);
      wait_rdy(40, edges);
      n_cmp++;
      if (edges !== 33 || data_result !== 32'h8000_0000 || data_remainder !== 32'h0 || data_exception !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL overflow: edges=%0d Q=%h R=%h exc=%b, required 33/80000000/0/1",
                  edges, data_result, data_remainder, data_exception);
      end
   endtask

   task automatic test_restart;
      int edges;
      logic early_rdy;
      early_rdy = 1'b0;
      start_op(32'd100, 32'd7);
      for (int i = 0; i < 9; i++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY === 1'b1) early_rdy = 1'b1;
      end
      start_op(32'd50, 32'd5);
      if (data_resultRDY === 1'b1) early_rdy = 1'b1;
      wait_rdy(40, edges);
      n_cmp++;
      if (early_rdy !== 1'b0 || edges !== 33) begin
         n_fail++;
         $display("[TB] FAIL restart_latency: early_rdy=%b edges=%0d, required 0/33", early_rdy, edges);
      end
      n_cmp++;
      if (data_result !== 32'd10 || data_remainder !== 32'd0 || data_exception !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL restart_result: Q=%0d R=%0d exc=%b, required 10/0/0",
                  data_result, data_remainder, data_exception);
      end
   endtask

   task automatic test_reset_midop;
      logic late_rdy;
      late_rdy = 1'b0;
      start_op(32'd100, 32'd7);
      repeat (15) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (data_result !== '0 || data_remainder !== '0 || data_exception !== 1'b0 ||
          data_resultRDY !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midop_reset: Q=%h R=%h exc=%b rdy=%b busy=%b, required all 0",
                  data_result, data_remainder, data_exception, data_resultRDY, busy);
      end
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY !== 1'b0 || busy !== 1'b0) late_rdy = 1'b1;
      end
      n_cmp++;
      if (late_rdy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midop_no_rdy: activity=%b, required 0", late_rdy);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_div_zero();
      test_overflow();
      test_restart();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
